rf_seq_ctrl: RTL and testbench

RF_SEQ_CTRL -- requirements
Module: rf_seq_ctrl

---
 rtl/rf_seq_ctrl.sv | 163 ++++++++++++++++
 tb/tb_rf_seq_ctrl.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rf_seq_ctrl.sv
// rtl/rf_seq_ctrl.sv - sequenced register-file ALU controller (IDLE/READ/EXEC/WRITE); define RF_SEQ_SAT_EN for saturating ADD/SUB
module rf_seq_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [2:0] cmd_op,
  input  logic [2:0] cmd_rd,
  input  logic [2:0] cmd_rs1,
  input  logic [2:0] cmd_rs2,
  input  logic [7:0] cmd_imm,
  output logic [2:0] read_addr1,
  output logic [2:0] read_addr2,
  input  logic [7:0] read_data1,
  input  logic [7:0] read_data2,
  output logic       we,
  output logic [2:0] write_addr,
  output logic [7:0] write_data,
  output logic       done,
  output logic [7:0] result,
  output logic       flag_z,
  output logic       flag_c
);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_LDI = 3'b101;
  localparam logic [2:0] OP_MOV = 3'b110;
  localparam logic [2:0] OP_NOP = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_EXEC  = 2'd2,
    S_WRITE = 2'd3
  } state_t;

  state_t     state_q;
  state_t     state_d;
  logic       accept;

  logic [2:0] op_q;
  logic [2:0] rd_q;
  logic [7:0] imm_q;
  logic [7:0] opa_q;
  logic [7:0] opb_q;

  logic [8:0] sum9;
  logic [8:0] diff9;
  logic [7:0] alu_res;
  logic       alu_c;

  // State register; reset drops any in-flight command
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and handshake/write-strobe decode
  always_comb begin
    state_d   = state_q;
    cmd_ready = 1'b0;
    accept    = 1'b0;
    we        = 1'b0;
    done      = 1'b0;
    case (state_q)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          accept  = 1'b1;
          // LDI and NOP need no operands, so they skip the read cycle
          state_d = (cmd_op == OP_LDI || cmd_op == OP_NOP) ? S_EXEC : S_READ;
        end
      end
      S_READ:  state_d = S_EXEC;
      S_EXEC:  state_d = S_WRITE;
      S_WRITE: begin
        done    = 1'b1;
        we      = (op_q != OP_NOP);
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // ALU: result and carry/borrow for the registered opcode
  always_comb begin
    sum9    = {1'b0, opa_q} + {1'b0, opb_q};
    diff9   = {1'b0, opa_q} - {1'b0, opb_q};
    alu_res = result;
    alu_c   = 1'b0;
    case (op_q)
      OP_ADD: begin
        alu_c = sum9[8];
`ifdef RF_SEQ_SAT_EN
        alu_res = sum9[8] ? 8'hFF : sum9[7:0];
`else
        alu_res = sum9[7:0];
`endif
      end
      OP_SUB: begin
        // borrow out of the 9-bit difference means opa < opb unsigned
        alu_c = diff9[8];
`ifdef RF_SEQ_SAT_EN
        alu_res = diff9[8] ? 8'h00 : diff9[7:0];
`else
        alu_res = diff9[7:0];
`endif
      end
      OP_AND:  alu_res = opa_q & opb_q;
      OP_OR:   alu_res = opa_q | opb_q;
      OP_XOR:  alu_res = opa_q ^ opb_q;
      OP_LDI:  alu_res = imm_q;
      OP_MOV:  alu_res = opa_q;
      default: alu_res = result;
    endcase
  end

  // Command capture, operand capture and result/flag/write-port registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q       <= OP_NOP;
      rd_q       <= 3'd0;
      imm_q      <= 8'd0;
      opa_q      <= 8'd0;
      opb_q      <= 8'd0;
      read_addr1 <= 3'd0;
      read_addr2 <= 3'd0;
      write_addr <= 3'd0;
      write_data <= 8'd0;
      result     <= 8'd0;
      flag_z     <= 1'b1;
      flag_c     <= 1'b0;
    end else begin
      if (accept) begin
        op_q       <= cmd_op;
        rd_q       <= cmd_rd;
        imm_q      <= cmd_imm;
        read_addr1 <= cmd_rs1;
        read_addr2 <= cmd_rs2;
      end
      // Operands are sampled before any write of this command, so rd may alias rs1/rs2
      if (state_q == S_READ) begin
        opa_q <= read_data1;
        opb_q <= read_data2;
      end
      if (state_q == S_EXEC && op_q != OP_NOP) begin
        result     <= alu_res;
        flag_c     <= alu_c;
        flag_z     <= (alu_res == 8'd0);
        write_addr <= rd_q;
        write_data <= alu_res;
      end
    end
  end

endmodule

// File: tb/tb_rf_seq_ctrl.sv
// tb/tb_rf_seq_ctrl.sv - directed self-checking bench for rf_seq_ctrl
module tb_rf_seq_ctrl;

  logic       clk;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_op;
  logic [2:0] cmd_rd;
  logic [2:0] cmd_rs1;
  logic [2:0] cmd_rs2;
  logic [7:0] cmd_imm;
  logic [2:0] read_addr1;
  logic [2:0] read_addr2;
  logic [7:0] read_data1;
  logic [7:0] read_data2;
  logic       we;
  logic [2:0] write_addr;
  logic [7:0] write_data;
  logic       done;
  logic [7:0] result;
  logic       flag_z;
  logic       flag_c;

  logic [7:0] rf [8];

  int n_checks = 0;
  int n_errors = 0;

  rf_seq_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_rd     (cmd_rd),
    .cmd_rs1    (cmd_rs1),
    .cmd_rs2    (cmd_rs2),
    .cmd_imm    (cmd_imm),
    .read_addr1 (read_addr1),
    .read_addr2 (read_addr2),
    .read_data1 (read_data1),
    .read_data2 (read_data2),
    .we         (we),
    .write_addr (write_addr),
    .write_data (write_data),
    .done       (done),
    .result     (result),
    .flag_z     (flag_z),
    .flag_c     (flag_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register-file model behind the controller
  assign read_data1 = rf[read_addr1];
  assign read_data2 = rf[read_addr2];
  always @(posedge clk) begin
    if (we) rf[write_addr] <= write_data;
  end

  localparam logic [2:0] ADD = 3'b000, SUB = 3'b001, AND_ = 3'b010, OR_ = 3'b011;
  localparam logic [2:0] XOR_ = 3'b100, LDI = 3'b101, MOV = 3'b110, NOP = 3'b111;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Issue one command, follow it to done, check latency and the write port
  task automatic run_cmd(input string tag, input logic [2:0] op, input logic [2:0] rd,
                         input logic [2:0] rs1, input logic [2:0] rs2, input logic [7:0] imm,
                         input int exp_lat, input logic exp_we, input logic [2:0] exp_addr,
                         input logic [7:0] exp_data);
    int  cyc;
    int  we_cnt;
    bit  seen;
    @(negedge clk);
    cmd_op = op; cmd_rd = rd; cmd_rs1 = rs1; cmd_rs2 = rs2; cmd_imm = imm;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    // fields scrambled after accept must not matter
    cmd_op = ~op; cmd_rd = ~rd; cmd_rs1 = ~rs1; cmd_rs2 = ~rs2; cmd_imm = ~imm;
    check_eq({tag, "_ready_low"}, {31'd0, cmd_ready}, 32'd0);
    cyc = 0; we_cnt = 0; seen = 0;
    while (!seen && cyc < 8) begin
      @(posedge clk);
      #1;
      cyc++;
      if (we) we_cnt++;
      if (done) begin
        seen = 1;
        check_eq({tag, "_latency"}, cyc + 1, exp_lat);
        check_eq({tag, "_we"}, {31'd0, we}, {31'd0, exp_we});
        check_eq({tag, "_waddr"}, {29'd0, write_addr}, {29'd0, exp_addr});
        check_eq({tag, "_wdata"}, {24'd0, write_data}, {24'd0, exp_data});
      end
    end
    if (!seen) check_eq({tag, "_done_timeout"}, 32'd0, 32'd1);
    @(posedge clk);
    #1;
    check_eq({tag, "_done_1cyc"}, {31'd0, done}, 32'd0);
    check_eq({tag, "_back_idle"}, {31'd0, cmd_ready}, 32'd1);
    check_eq({tag, "_we_count"}, we_cnt, {31'd0, exp_we});
  endtask

  initial begin
    int acc_cnt;
    int wr_cnt;
    int acc_at [3];
    rst = 1'b1; cmd_valid = 1'b0;
    cmd_op = NOP; cmd_rd = 0; cmd_rs1 = 0; cmd_rs2 = 0; cmd_imm = 0;
    for (int i = 0; i < 8; i++) rf[i] = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_eq("rst_we", {31'd0, we}, 32'd0);
    check_eq("rst_done", {31'd0, done}, 32'd0);
    check_eq("rst_ready", {31'd0, cmd_ready}, 32'd1);
    check_eq("rst_raddr1", {29'd0, read_addr1}, 32'd0);
    check_eq("rst_raddr2", {29'd0, read_addr2}, 32'd0);
    check_eq("rst_waddr", {29'd0, write_addr}, 32'd0);
    check_eq("rst_wdata", {24'd0, write_data}, 32'd0);
    check_eq("rst_result", {24'd0, result}, 32'd0);
    check_eq("rst_z", {31'd0, flag_z}, 32'd1);
    check_eq("rst_c", {31'd0, flag_c}, 32'd0);

    // Reset in the middle of READ for ADD r3=r1+r2
    rf[1] = 8'h11; rf[2] = 8'h22;
    @(negedge clk);
    cmd_op = ADD; cmd_rd = 3; cmd_rs1 = 1; cmd_rs2 = 2; cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    check_eq("mid_raddr1", {29'd0, read_addr1}, 32'd1);
    check_eq("mid_raddr2", {29'd0, read_addr2}, 32'd2);
    #2 rst = 1'b1;
    #1;
    check_eq("mid_ready_in_rst", {31'd0, cmd_ready}, 32'd1);
    @(negedge clk);
    rst = 1'b0;
    wr_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      if (we) wr_cnt++;
    end
    check_eq("mid_no_write", wr_cnt, 32'd0);
    check_eq("mid_ready", {31'd0, cmd_ready}, 32'd1);
    check_eq("mid_result", {24'd0, result}, 32'd0);
    check_eq("mid_z", {31'd0, flag_z}, 32'd1);
    check_eq("mid_rf3", {24'd0, rf[3]}, 32'd0);

    // LDI r0,0x55 then MOV r1,r0
    run_cmd("ldi", LDI, 3'd0, 3'd7, 3'd7, 8'h55, 2, 1'b1, 3'd0, 8'h55);
    check_eq("ldi_result", {24'd0, result}, 32'h55);
    check_eq("ldi_z", {31'd0, flag_z}, 32'd0);
    run_cmd("mov", MOV, 3'd1, 3'd0, 3'd0, 8'h00, 3, 1'b1, 3'd1, 8'h55);
    check_eq("mov_rf1", {24'd0, rf[1]}, 32'h55);

    // ADD with carry out
    rf[1] = 8'hAA; rf[2] = 8'h66;
`ifdef RF_SEQ_SAT_EN
    run_cmd("add_c", ADD, 3'd3, 3'd1, 3'd2, 8'h00, 3, 1'b1, 3'd3, 8'hFF);
`else
    run_cmd("add_c", ADD, 3'd3, 3'd1, 3'd2, 8'h00, 3, 1'b1, 3'd3, 8'h10);
`endif
    check_eq("add_c_flag", {31'd0, flag_c}, 32'd1);
    check_eq("add_z_flag", {31'd0, flag_z}, 32'd0);

    // SUB equal operands, rd aliases rs1
    rf[1] = 8'h05; rf[2] = 8'h05;
    run_cmd("sub_eq", SUB, 3'd1, 3'd1, 3'd2, 8'h00, 3, 1'b1, 3'd1, 8'h00);
    check_eq("sub_eq_z", {31'd0, flag_z}, 32'd1);
    check_eq("sub_eq_c", {31'd0, flag_c}, 32'd0);

    // SUB with borrow
    rf[1] = 8'h03; rf[2] = 8'h05;
`ifdef RF_SEQ_SAT_EN
    run_cmd("sub_b", SUB, 3'd4, 3'd1, 3'd2, 8'h00, 3, 1'b1, 3'd4, 8'h00);
    check_eq("sub_b_z", {31'd0, flag_z}, 32'd1);
`else
    run_cmd("sub_b", SUB, 3'd4, 3'd1, 3'd2, 8'h00, 3, 1'b1, 3'd4, 8'hFE);
    check_eq("sub_b_z", {31'd0, flag_z}, 32'd0);
`endif
    check_eq("sub_b_c", {31'd0, flag_c}, 32'd1);

    // NOP keeps result, flags and held write port
`ifdef RF_SEQ_SAT_EN
    run_cmd("nop", NOP, 3'd6, 3'd1, 3'd2, 8'h00, 2, 1'b0, 3'd4, 8'h00);
    check_eq("nop_result", {24'd0, result}, 32'h00);
    check_eq("nop_z", {31'd0, flag_z}, 32'd1);
`else
    run_cmd("nop", NOP, 3'd6, 3'd1, 3'd2, 8'h00, 2, 1'b0, 3'd4, 8'hFE);
    check_eq("nop_result", {24'd0, result}, 32'hFE);
    check_eq("nop_z", {31'd0, flag_z}, 32'd0);
`endif
    check_eq("nop_c", {31'd0, flag_c}, 32'd1);
    check_eq("nop_rf6", {24'd0, rf[6]}, 32'd0);

    // Bitwise ops clear carry
    rf[5] = 8'hF0; rf[6] = 8'h3C;
    run_cmd("and", AND_, 3'd7, 3'd5, 3'd6, 8'h00, 3, 1'b1, 3'd7, 8'h30);
    check_eq("and_c", {31'd0, flag_c}, 32'd0);
    run_cmd("or", OR_, 3'd7, 3'd5, 3'd6, 8'h00, 3, 1'b1, 3'd7, 8'hFC);
    run_cmd("xor", XOR_, 3'd7, 3'd5, 3'd6, 8'h00, 3, 1'b1, 3'd7, 8'hCC);

    // Back-to-back XOR with cmd_valid held high
    rf[0] = 8'h0F; rf[1] = 8'hFF;
    @(negedge clk);
    cmd_op = XOR_; cmd_rd = 3'd2; cmd_rs1 = 3'd0; cmd_rs2 = 3'd1; cmd_imm = 8'h00;
    cmd_valid = 1'b1;
    acc_cnt = 0; wr_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      if (cmd_ready) begin
        if (acc_cnt < 3) acc_at[acc_cnt] = i;
        acc_cnt++;
      end
      if (we) begin
        wr_cnt++;
        check_eq("b2b_wdata", {24'd0, write_data}, 32'hF0);
      end
      if (i == 11) cmd_valid = 1'b0;
      else @(negedge clk);
    end
    check_eq("b2b_accepts", acc_cnt, 32'd3);
    check_eq("b2b_writes", wr_cnt, 32'd3);
    check_eq("b2b_gap1", acc_at[1] - acc_at[0], 32'd4);
    check_eq("b2b_gap2", acc_at[2] - acc_at[1], 32'd4);
    repeat (6) @(posedge clk);
    #1;
    check_eq("b2b_idle", {31'd0, cmd_ready}, 32'd1);
    check_eq("b2b_rf2", {24'd0, rf[2]}, 32'hF0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
